// File: rtl/io_retire_sequencer.sv
// io_retire_sequencer: in-order queue of IO ops that waits for each head op to
// commit, checks its privilege, fires it at the IO unit and reports completion
// or a privilege fault back to the ROB.

package io_retire_pkg;
   // Op spec carried alongside each queued IO op.
   typedef struct packed {
      logic [1:0] kind;
      logic [5:0] port;
   } op_t;
endpackage

// Handshake: an op is enqueued on a rising clk edge when enq_valid_i && enq_ready_o;
// enq_ready_o depends only on registered occupancy and flush_i, never on a pop
// happening in the same cycle.
module io_retire_sequencer
   import io_retire_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enq_valid_i,
   output logic                       enq_ready_o,
   input  logic [TAG_W-1:0]           enq_tag_i,
   input  op_t                        enq_op_i,
   input  logic                       enq_cpl_i,
   input  logic                       commit_valid_i,
   input  logic [TAG_W-1:0]           commit_tag_i,
   input  logic                       flush_i,
   output logic                       io_retire_o,
   output op_t                        io_op_o,
   output logic                       io_cpl_o,
   input  logic                       io_done_i,
   output logic                       done_valid_o,
   output logic [TAG_W-1:0]           done_tag_o,
   output logic                       fault_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_COMMIT,
      S_ISSUE,
      S_WAIT_DONE,
      S_REPORT,
      S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   // Entry storage is not reset: every read is qualified by count_q != 0.
   logic [TAG_W-1:0]  tag_mem_q [DEPTH];
   op_t               op_mem_q  [DEPTH];
   logic              cpl_mem_q [DEPTH];

   logic              enq_ready;
   logic              enq_fire;
   logic              pop;
   logic              head_valid;
   logic [TAG_W-1:0]  head_tag;
   logic              head_cpl;
   logic              speculative_state;

   assign enq_ready  = rst && (count_q != CW'(DEPTH)) && !flush_i;
   assign enq_fire   = enq_valid_i && enq_ready;
   assign pop        = (state_q == S_REPORT) || (state_q == S_FAULT);
   assign head_valid = (count_q != '0);
   assign head_tag   = tag_mem_q[head_q];
   assign head_cpl   = cpl_mem_q[head_q];
   // In IDLE/WAIT_COMMIT nothing has been sent to the IO unit, so a flush may
   // drop the whole queue; later states own an in-flight head that must survive.
   assign speculative_state = (state_q == S_IDLE) || (state_q == S_WAIT_COMMIT);

   // Retire sequencing for the head entry.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!flush_i && head_valid) state_d = S_WAIT_COMMIT;
         end
         S_WAIT_COMMIT: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (commit_valid_i && (commit_tag_i == head_tag)) begin
               state_d = head_cpl ? S_ISSUE : S_FAULT;
            end
         end
         S_ISSUE:     state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (io_done_i) state_d = S_REPORT;
         end
         S_REPORT:    state_d = S_IDLE;
         S_FAULT:     state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Pointer and occupancy update, including the two flavours of flush.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         if (speculative_state) begin
            tail_d  = head_q;
            count_d = '0;
         end else if (pop) begin
            head_d  = head_q + PW'(1);
            tail_d  = head_q + PW'(1);
            count_d = '0;
         end else begin
            tail_d  = head_q + PW'(1);
            count_d = CW'(1);
         end
      end else begin
         if (enq_fire) tail_d = tail_q + PW'(1);
         if (pop)      head_d = head_q + PW'(1);
         unique case ({enq_fire, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry write at the tail on an accepted enqueue.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         tag_mem_q[tail_q] <= enq_tag_i;
         op_mem_q[tail_q]  <= enq_op_i;
         cpl_mem_q[tail_q] <= enq_cpl_i;
      end
   end

   // Outputs are forced low while rst is asserted, even before the first edge.
   assign enq_ready_o  = enq_ready;
   assign io_retire_o  = rst && (state_q == S_ISSUE);
   assign done_valid_o = rst && pop;
   assign fault_o      = rst && (state_q == S_FAULT);
   assign done_tag_o   = (rst && head_valid) ? head_tag : '0;
   assign io_op_o      = (rst && head_valid) ? op_mem_q[head_q] : '0;
   assign io_cpl_o     = rst && head_valid && head_cpl;
   assign count_o      = rst ? count_q : '0;

endmodule
